// File: rtl/cacheline_adaptor.sv
// ============================================================================
//  Module      : cacheline_adaptor
//  Description : Bridges 256-bit cache line transfers to 4-beat 64-bit memory
//                bursts (read assembly, write split).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cacheline_adaptor (
    input  logic         clk,
    input  logic         rst,

    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    input  logic [31:0]  address_i,
    input  logic         read_i,
    input  logic         write_i,
    output logic         resp_o,

    input  logic [63:0]  burst_i,
    output logic [63:0]  burst_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    input  logic         resp_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] C_LAST_BEAT = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [1:0]   r_cnt;
    logic [31:0]  r_addr;
    logic [255:0] r_wline;
    logic [255:0] r_rline;
    logic [7:0]   w_beat_base;

    assign w_beat_base = {r_cnt, 6'd0};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // Read has priority when both requests arrive together.
                if (read_i)
                    w_state_nxt = S_READ;
                else if (write_i)
                    w_state_nxt = S_WRITE;
            end
            S_READ:  if (resp_i && r_cnt == C_LAST_BEAT) w_state_nxt = S_DONE;
            S_WRITE: if (resp_i && r_cnt == C_LAST_BEAT) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_addr  <= 32'd0;
            r_wline <= 256'd0;
            r_rline <= 256'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (read_i) begin
                        r_addr <= address_i;
                        r_cnt  <= 2'd0;
                    end else if (write_i) begin
                        r_addr  <= address_i;
                        r_wline <= line_i;
                        r_cnt   <= 2'd0;
                    end
                end
                S_READ: begin
                    if (resp_i) begin
                        r_rline[w_beat_base +: 64] <= burst_i;
                        r_cnt                      <= r_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (resp_i)
                        r_cnt <= r_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Every output is a decode of registered state only.
    assign line_o    = r_rline;
    assign resp_o    = (r_state == S_DONE);
    assign read_o    = (r_state == S_READ);
    assign write_o   = (r_state == S_WRITE);
    assign address_o = {r_addr[31:5], 5'd0};
    assign burst_o   = (r_state == S_WRITE) ? r_wline[w_beat_base +: 64] : 64'd0;

endmodule

`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
// ============================================================================
//  Module      : tb_cacheline_adaptor
//  Description : Directed self-checking bench for cacheline_adaptor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    localparam logic [255:0] C_LINE_A = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    localparam logic [255:0] C_LINE_W = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    localparam logic [255:0] C_LINE_G = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                         64'h5555_AAAA_5555_AAAA, 64'h0F0F_0F0F_F0F0_F0F0};
    localparam logic [255:0] C_LINE_R = {64'h1000_0000_0000_0004, 64'h1000_0000_0000_0003,
                                         64'h1000_0000_0000_0002, 64'h1000_0000_0000_0001};
    localparam logic [63:0]  C_JUNK   = 64'hDEAD_BEEF_0BAD_F00D;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts at a negedge in IDLE; returns at the negedge of the DONE cycle.
    task automatic read_burst(input logic [31:0] addr, input logic [255:0] line,
                              input logic [7:0] pat, input int ncyc,
                              output bit ro_ok, output bit wo_seen, output bit early_resp,
                              output bit addr_ok);
        int bi;
        bi = 0; ro_ok = 1'b1; wo_seen = 1'b0; early_resp = 1'b0; addr_ok = 1'b1;
        read_i = 1'b1; address_i = addr;
        @(negedge clk);
        for (int k = 0; k < ncyc; k++) begin
            if (read_o !== 1'b1) ro_ok = 1'b0;
            if (write_o !== 1'b0) wo_seen = 1'b1;
            if (resp_o !== 1'b0) early_resp = 1'b1;
            if (address_o !== {addr[31:5], 5'd0}) addr_ok = 1'b0;
            resp_i = pat[k];
            if (pat[k]) begin
                burst_i = line[64*bi +: 64];
                bi++;
            end else begin
                burst_i = C_JUNK;
            end
            @(negedge clk);
        end
        resp_i = 1'b0; burst_i = 64'd0; read_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [255:0] line,
                               input logic [7:0] pat, input int ncyc,
                               output logic [255:0] beats, output bit wo_ok,
                               output bit ro_seen, output bit addr_ok);
        int bi;
        bi = 0; beats = 256'd0; wo_ok = 1'b1; ro_seen = 1'b0; addr_ok = 1'b1;
        write_i = 1'b1; address_i = addr; line_i = line;
        @(negedge clk);
        for (int k = 0; k < ncyc; k++) begin
            if (write_o !== 1'b1) wo_ok = 1'b0;
            if (read_o !== 1'b0) ro_seen = 1'b1;
            if (address_o !== {addr[31:5], 5'd0}) addr_ok = 1'b0;
            if (pat[k]) begin
                beats[64*bi +: 64] = burst_o;
                bi++;
            end
            resp_i = pat[k];
            if (k == 1) line_i = ~line;
            @(negedge clk);
        end
        resp_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({line_o, resp_o, read_o, write_o, address_o, burst_o} !== '0)
            $display("FAIL reset_outputs: line_o=%h resp=%b rd=%b wr=%b addr=%h burst=%h, expected all 0",
                     line_o, resp_o, read_o, write_o, address_o, burst_o);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_contig();
        bit ro_ok, wo_seen, early, addr_ok;
        read_burst(32'h0000_1234, C_LINE_A, 8'b0000_1111, 4, ro_ok, wo_seen, early, addr_ok);
        chk_cnt++;
        if (!addr_ok) $display("FAIL rd_addr: address_o=%h expected 00001220", address_o);
        else pass_cnt++;
        chk_cnt++;
        if (!ro_ok || early) $display("FAIL rd_ctrl: read_o_held=%b early_resp=%b expected 1/0", ro_ok, early);
        else pass_cnt++;
        chk_cnt++;
        if (resp_o !== 1'b1 || read_o !== 1'b0)
            $display("FAIL rd_done: resp_o=%b read_o=%b expected 1/0", resp_o, read_o);
        else pass_cnt++;
        chk_cnt++;
        if (line_o !== C_LINE_A) $display("FAIL rd_line: line_o=%h expected %h", line_o, C_LINE_A);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || line_o !== C_LINE_A)
            $display("FAIL rd_after: resp_o=%b read_o=%b line_o=%h expected 0/0/%h", resp_o, read_o, line_o, C_LINE_A);
        else pass_cnt++;
    endtask

    task automatic test_read_gaps();
        bit ro_ok, wo_seen, early, addr_ok;
        read_burst(32'hABCD_EF7F, C_LINE_G, 8'b0101_1001, 7, ro_ok, wo_seen, early, addr_ok);
        chk_cnt++;
        if (!ro_ok || early || !addr_ok)
            $display("FAIL gap_ctrl: read_o_held=%b early_resp=%b addr_ok=%b expected 1/0/1", ro_ok, early, addr_ok);
        else pass_cnt++;
        chk_cnt++;
        if (resp_o !== 1'b1) $display("FAIL gap_resp: resp_o=%b expected 1", resp_o);
        else pass_cnt++;
        chk_cnt++;
        if (line_o !== C_LINE_G) $display("FAIL gap_line: line_o=%h expected %h", line_o, C_LINE_G);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [255:0] beats;
        bit wo_ok, ro_seen, addr_ok;
        write_burst(32'h8000_005F, C_LINE_W, 8'b0010_1101, 6, beats, wo_ok, ro_seen, addr_ok);
        chk_cnt++;
        if (beats !== C_LINE_W) $display("FAIL wr_beats: burst_o seq=%h expected %h", beats, C_LINE_W);
        else pass_cnt++;
        chk_cnt++;
        if (!wo_ok || ro_seen || !addr_ok)
            $display("FAIL wr_ctrl: write_o_held=%b read_o_seen=%b addr_ok=%b expected 1/0/1", wo_ok, ro_seen, addr_ok);
        else pass_cnt++;
        chk_cnt++;
        if (resp_o !== 1'b1 || write_o !== 1'b0 || burst_o !== 64'd0)
            $display("FAIL wr_done: resp_o=%b write_o=%b burst_o=%h expected 1/0/0", resp_o, write_o, burst_o);
        else pass_cnt++;
        chk_cnt++;
        if (line_o !== C_LINE_G) $display("FAIL wr_keep_line: line_o=%h expected %h", line_o, C_LINE_G);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (resp_o !== 1'b0) $display("FAIL wr_resp_once: resp_o=%b expected 0", resp_o);
        else pass_cnt++;
    endtask

    task automatic test_rd_wr_collide();
        bit ro_ok, wo_seen, early, addr_ok;
        write_i = 1'b1; line_i = C_LINE_W;
        read_burst(32'h0000_0100, C_LINE_A, 8'b0000_1111, 4, ro_ok, wo_seen, early, addr_ok);
        chk_cnt++;
        if (wo_seen || !ro_ok) $display("FAIL collide: write_o_seen=%b read_o_held=%b expected 0/1", wo_seen, ro_ok);
        else pass_cnt++;
        chk_cnt++;
        if (line_o !== C_LINE_A || resp_o !== 1'b1)
            $display("FAIL collide_line: line_o=%h resp_o=%b expected %h/1", line_o, resp_o, C_LINE_A);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        bit ro_ok, wo_seen, early, addr_ok;
        read_i = 1'b1; address_i = 32'h0000_4000;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            resp_i = 1'b1; burst_i = {32'hBAD0_0000, k};
            @(negedge clk);
        end
        rst = 1'b1; resp_i = 1'b1; burst_i = C_JUNK;
        @(negedge clk);
        chk_cnt++;
        if ({line_o, resp_o, read_o, write_o, address_o, burst_o} !== '0)
            $display("FAIL rst_mid: line_o=%h resp=%b rd=%b wr=%b addr=%h burst=%h, expected all 0",
                     line_o, resp_o, read_o, write_o, address_o, burst_o);
        else pass_cnt++;
        rst = 1'b0; resp_i = 1'b0; read_i = 1'b0; burst_i = 64'd0;
        @(negedge clk);
        read_burst(32'h0000_4020, C_LINE_R, 8'b0000_1111, 4, ro_ok, wo_seen, early, addr_ok);
        chk_cnt++;
        if (line_o !== C_LINE_R || resp_o !== 1'b1 || !addr_ok)
            $display("FAIL rst_fresh: line_o=%h resp_o=%b addr_ok=%b expected %h/1/1", line_o, resp_o, addr_ok, C_LINE_R);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ro_ok, wo_seen, early, addr_ok;
        logic [255:0] beats;
        bit wo_ok, ro_seen;
        read_burst(32'h0000_2000, C_LINE_G, 8'b0000_1111, 4, ro_ok, wo_seen, early, addr_ok);
        chk_cnt++;
        if (resp_o !== 1'b1 || line_o !== C_LINE_G)
            $display("FAIL b2b_rd: resp_o=%b line_o=%h expected 1/%h", resp_o, line_o, C_LINE_G);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (resp_o !== 1'b0) $display("FAIL b2b_gap: resp_o=%b expected 0", resp_o);
        else pass_cnt++;
        write_burst(32'h0000_3000, C_LINE_W, 8'b0000_1111, 4, beats, wo_ok, ro_seen, addr_ok);
        chk_cnt++;
        if (beats !== C_LINE_W || !wo_ok || ro_seen)
            $display("FAIL b2b_wr: beats=%h write_o_held=%b read_o_seen=%b expected %h/1/0", beats, wo_ok, ro_seen, C_LINE_W);
        else pass_cnt++;
        chk_cnt++;
        if (resp_o !== 1'b1 || line_o !== C_LINE_G)
            $display("FAIL b2b_wr_done: resp_o=%b line_o=%h expected 1/%h", resp_o, line_o, C_LINE_G);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; line_i = 256'd0; address_i = 32'd0; read_i = 1'b0;
        write_i = 1'b0; burst_i = 64'd0; resp_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_read_contig();
        test_read_gaps();
        test_write();
        test_rd_wr_collide();
        test_reset_mid_read();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
